timer_apb_regs: RTL and testbench



---
 rtl/timer_pkg.sv | 29 ++
 rtl/timer_apb_fsm.sv | 76 +++++++
 rtl/timer_apb_regs.sv | 103 ++++++++++
 tb/tb_timer_apb_regs.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared constants for the timer APB register block: register addresses,
// control/status bit positions and the bus state machine encoding.
package timer_pkg;

    // Register addresses
    localparam logic [7:0] ADDR_TDR  = 8'h00;
    localparam logic [7:0] ADDR_TCR  = 8'h01;
    localparam logic [7:0] ADDR_TSR  = 8'h02;
    localparam logic [7:0] ADDR_TCNT = 8'h03;

    // TCR bit positions
    localparam int unsigned TCR_LOAD   = 7;
    localparam int unsigned TCR_UPDN   = 5;
    localparam int unsigned TCR_EN     = 4;
    localparam int unsigned TCR_CKS_HI = 1;
    localparam int unsigned TCR_CKS_LO = 0;

    // TSR bit positions
    localparam int unsigned TSR_OVF = 0;
    localparam int unsigned TSR_UDF = 1;

    // APB responder states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

endpackage

// File: rtl/timer_apb_fsm.sv
// APB handshake state machine: tracks setup/access phases, counts wait
// states and produces a one-cycle pready plus commit strobes for the
// register file.
module timer_apb_fsm
    import timer_pkg::*;
#(
    parameter int WAIT_CYCLES = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic psel,
    input  logic penable,
    input  logic pwrite,
    output logic pready,
    output logic wr_commit,
    output logic rd_valid
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    apb_state_t state_q;
    apb_state_t phase;
    logic [3:0] wait_cnt;

    // The setup phase is recognised in the same cycle the bus presents it,
    // so SETUP is decoded from IDLE plus the bus pins rather than stored;
    // this keeps a zero-wait transfer at two cycles with a registered pready.
    always_comb begin
        phase = state_q;
        if (state_q == IDLE && psel && !penable) begin
            phase = SETUP;
        end
    end

    // Advance the handshake, count wait states and raise pready for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wait_cnt <= 4'd0;
            pready   <= 1'b0;
        end else begin
            case (phase)
                IDLE: begin
                    pready <= 1'b0;
                end
                SETUP: begin
                    wait_cnt <= WAIT_INIT;
                    pready   <= (WAIT_INIT == 4'd0);
                    state_q  <= ACCESS;
                end
                ACCESS: begin
                    if (!psel) begin
                        state_q <= IDLE;
                        pready  <= 1'b0;
                    end else if (pready) begin
                        state_q <= IDLE;
                        pready  <= 1'b0;
                    end else if (penable) begin
                        if (wait_cnt <= 4'd1) begin
                            pready <= 1'b1;
                        end
                        wait_cnt <= (wait_cnt == 4'd0) ? 4'd0 : wait_cnt - 4'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    pready  <= 1'b0;
                end
            endcase
        end
    end

    assign wr_commit = pready && psel && penable && pwrite;
    assign rd_valid  = pready && psel && penable && !pwrite;

endmodule

// File: rtl/timer_apb_regs.sv
// Register file for the 8-bit timer: turns APB writes into counter controls
// and pulses, and returns counter status and count on APB reads.
module timer_apb_regs
    import timer_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [7:0]        pwdata,
    output logic [7:0]        prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [7:0]        start_counter,
    output logic              load,
    output logic              up_down,
    output logic              enable,
    output logic [1:0]        cks,
    output logic              clr_overflow,
    output logic              clr_underflow,
    input  logic              overflow,
    input  logic              underflow,
    input  logic [7:0]        tcnt
);

    logic       wr_commit;
    logic       rd_valid;
    logic       addr_ok;
    logic [7:0] rd_mux;

    timer_apb_fsm #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_fsm (
        .clk      (clk),
        .rst      (rst),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .pready   (pready),
        .wr_commit(wr_commit),
        .rd_valid (rd_valid)
    );

    // Only the four lowest addresses are mapped; anything above errors out.
    assign addr_ok = (paddr[ADDR_W-1:2] == '0);
    assign pslverr = pready && !addr_ok;

    // Apply committed writes; load and flag clears default low so they pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_counter <= 8'h00;
            up_down       <= 1'b0;
            enable        <= 1'b0;
            cks           <= 2'b00;
            load          <= 1'b0;
            clr_overflow  <= 1'b0;
            clr_underflow <= 1'b0;
        end else begin
            load          <= 1'b0;
            clr_overflow  <= 1'b0;
            clr_underflow <= 1'b0;
            if (wr_commit && addr_ok) begin
                case (paddr[1:0])
                    ADDR_TDR[1:0]: begin
                        start_counter <= pwdata;
                    end
                    ADDR_TCR[1:0]: begin
                        load    <= pwdata[TCR_LOAD];
                        up_down <= pwdata[TCR_UPDN];
                        enable  <= pwdata[TCR_EN];
                        cks     <= pwdata[TCR_CKS_HI:TCR_CKS_LO];
                    end
                    ADDR_TSR[1:0]: begin
                        clr_overflow  <= pwdata[TSR_OVF];
                        clr_underflow <= pwdata[TSR_UDF];
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Select the addressed register; TCR LOAD and reserved bits read as zero.
    always_comb begin
        rd_mux = 8'h00;
        case (paddr[1:0])
            ADDR_TDR[1:0]:  rd_mux = start_counter;
            ADDR_TCR[1:0]:  rd_mux = {2'b00, up_down, enable, 2'b00, cks};
            ADDR_TSR[1:0]:  rd_mux = {6'b000000, underflow, overflow};
            ADDR_TCNT[1:0]: rd_mux = tcnt;
            default:        rd_mux = 8'h00;
        endcase
    end

    assign prdata = (rd_valid && addr_ok) ? rd_mux : 8'h00;

endmodule

// File: tb/tb_timer_apb_regs.sv
// Testbench for timer_apb_regs: a zero-wait instance exercised with directed
// and random transfers against a register-map model, plus a three-wait
// instance used for wait-state, abort and reset-during-transfer behaviour.
module tb_timer_apb_regs;

    logic       clk = 1'b0;
    logic       rst;
    logic       rst3;
    logic       psel;
    logic       sel3;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic       overflow;
    logic       underflow;
    logic [7:0] tcnt;

    logic       psel0;
    logic       psel3;
    assign psel0 = psel && !sel3;
    assign psel3 = psel && sel3;

    logic [7:0] prdata0, start_counter0;
    logic       pready0, pslverr0, load0, up_down0, enable0, clr_ovf0, clr_udf0;
    logic [1:0] cks0;

    logic [7:0] prdata3, start_counter3;
    logic       pready3, pslverr3, load3, up_down3, enable3, clr_ovf3, clr_udf3;
    logic [1:0] cks3;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model of the software-visible register state
    logic [7:0] m_tdr;
    logic [7:0] m_tcr;

    always #5 clk = ~clk;

    timer_apb_regs #(.ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .psel(psel0), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata0), .pready(pready0),
        .pslverr(pslverr0), .start_counter(start_counter0), .load(load0),
        .up_down(up_down0), .enable(enable0), .cks(cks0),
        .clr_overflow(clr_ovf0), .clr_underflow(clr_udf0),
        .overflow(overflow), .underflow(underflow), .tcnt(tcnt)
    );

    timer_apb_regs #(.ADDR_W(8), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst3), .psel(psel3), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata3), .pready(pready3),
        .pslverr(pslverr3), .start_counter(start_counter3), .load(load3),
        .up_down(up_down3), .enable(enable3), .cks(cks3),
        .clr_overflow(clr_ovf3), .clr_underflow(clr_udf3),
        .overflow(overflow), .underflow(underflow), .tcnt(tcnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h, required %0h", tag, observed, expected);
        end
    endtask

    // One full APB transfer; returns read data, error flag and the number of
    // access-phase cycles up to and including the pready cycle. Returns just
    // after the commit edge with the bus released.
    task automatic applyStimulus(input bit to3, input bit wr, input logic [7:0] addr,
                                 input logic [7:0] data, output logic [7:0] rdata,
                                 output logic err, output int cycles);
        bit done;
        done   = 1'b0;
        rdata  = 8'h00;
        err    = 1'b0;
        @(posedge clk); #1;
        sel3 = to3; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
        @(posedge clk); #1;
        penable = 1'b1;
        cycles  = 1;
        while (!done && cycles < 40) begin
            @(negedge clk);
            if ((to3 ? pready3 : pready0) === 1'b1) begin
                rdata = to3 ? prdata3 : prdata0;
                err   = to3 ? pslverr3 : pslverr0;
                done  = 1'b1;
            end else begin
                @(posedge clk); #1;
                cycles++;
            end
        end
        if (!done) checkOutput("xfer_timeout", 32'(done), 32'd1);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    // Expected read data from the register map rules
    function automatic logic [7:0] modelRead(input logic [7:0] a);
        case (a)
            8'h00:   return m_tdr;
            8'h01:   return m_tcr;
            8'h02:   return {6'd0, underflow, overflow};
            8'h03:   return tcnt;
            default: return 8'h00;
        endcase
    endfunction

    // Apply a write to the model; returns expected {load, clr_ovf, clr_udf}
    task automatic modelWrite(input logic [7:0] a, input logic [7:0] d, output logic [2:0] pulses);
        pulses = 3'b000;
        if (a == 8'h00) m_tdr = d;
        if (a == 8'h01) begin
            m_tcr  = d & 8'h33;
            pulses = {d[7], 2'b00};
        end
        if (a == 8'h02) pulses = {1'b0, d[0], d[1]};
    endtask

    initial begin
        logic [7:0] rd;
        logic       er;
        int         cyc;
        logic [2:0] pul;
        bit         saw;
        logic [7:0] a, d;
        bit         w;

        rst = 1'b1; rst3 = 1'b1;
        psel = 1'b0; sel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 8'h00; pwdata = 8'h00;
        overflow = 1'b0; underflow = 1'b1; tcnt = 8'h3C;
        m_tdr = 8'h00; m_tcr = 8'h00;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0; rst3 = 1'b0;

        @(negedge clk);
        checkOutput("reset_outputs",
            {start_counter0, load0, up_down0, enable0, cks0, clr_ovf0, clr_udf0, pready0, pslverr0, prdata0}, 0);
        checkOutput("reset_outputs_w3",
            {start_counter3, load3, up_down3, enable3, cks3, clr_ovf3, clr_udf3, pready3, pslverr3, prdata3}, 0);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 8'(i), 8'h00, rd, er, cyc);
            checkOutput($sformatf("reset_read_%0d", i), {er, rd}, {1'b0, modelRead(8'(i))});
        end

        // TDR write with no wait states
        applyStimulus(1'b0, 1'b1, 8'h00, 8'hA5, rd, er, cyc);
        modelWrite(8'h00, 8'hA5, pul);
        checkOutput("tdr_cycles", 32'(cyc), 32'd1);
        @(negedge clk);
        checkOutput("tdr_value", start_counter0, 8'hA5);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, rd, er, cyc);
        checkOutput("tdr_read", rd, 8'hA5);

        // TCR write with LOAD and enable together
        applyStimulus(1'b0, 1'b1, 8'h01, 8'hB2, rd, er, cyc);
        modelWrite(8'h01, 8'hB2, pul);
        @(negedge clk);
        checkOutput("tcr_fields", {load0, up_down0, enable0, cks0}, {1'b1, 1'b1, 1'b1, 2'b10});
        @(negedge clk);
        checkOutput("tcr_load_end", load0, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h01, 8'h00, rd, er, cyc);
        checkOutput("tcr_read", rd, 8'h32);

        // Flag clears
        overflow = 1'b1; underflow = 1'b1;
        applyStimulus(1'b0, 1'b1, 8'h02, 8'h01, rd, er, cyc);
        @(negedge clk);
        checkOutput("tsr_clr_ovf", {clr_ovf0, clr_udf0}, 2'b10);
        @(negedge clk);
        checkOutput("tsr_clr_end", {clr_ovf0, clr_udf0}, 2'b00);
        applyStimulus(1'b0, 1'b1, 8'h02, 8'h03, rd, er, cyc);
        @(negedge clk);
        checkOutput("tsr_clr_both", {clr_ovf0, clr_udf0}, 2'b11);

        // Unmapped address
        applyStimulus(1'b0, 1'b1, 8'h07, 8'hFF, rd, er, cyc);
        checkOutput("bad_wr_err", er, 1'b1);
        @(negedge clk);
        checkOutput("bad_wr_no_effect",
            {start_counter0, up_down0, enable0, cks0, load0, clr_ovf0, clr_udf0},
            {m_tdr, m_tcr[5], m_tcr[4], m_tcr[1:0], 3'b000});
        applyStimulus(1'b0, 1'b0, 8'h07, 8'h00, rd, er, cyc);
        checkOutput("bad_rd", {er, rd}, {1'b1, 8'h00});

        // Random transfers against the model
        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom_range(0, 5));
            d = 8'($urandom);
            w = 1'($urandom_range(0, 1));
            overflow  = 1'($urandom);
            underflow = 1'($urandom);
            tcnt      = 8'($urandom);
            applyStimulus(1'b0, w, a, d, rd, er, cyc);
            checkOutput("rnd_err", er, (a > 8'h03));
            checkOutput("rnd_cycles", 32'(cyc), 32'd1);
            if (!w) checkOutput("rnd_rdata", rd, modelRead(a));
            pul = 3'b000;
            if (w && a <= 8'h03) modelWrite(a, d, pul);
            @(negedge clk);
            checkOutput("rnd_pulses", {load0, clr_ovf0, clr_udf0}, pul);
            checkOutput("rnd_regs", {start_counter0, up_down0, enable0, cks0},
                        {m_tdr, m_tcr[5], m_tcr[4], m_tcr[1:0]});
            @(negedge clk);
            checkOutput("rnd_pulse_end", {load0, clr_ovf0, clr_udf0}, 3'b000);
        end

        // Three wait states: pready on the fourth access cycle
        applyStimulus(1'b1, 1'b1, 8'h00, 8'h5C, rd, er, cyc);
        checkOutput("wait3_cycles", 32'(cyc), 32'd4);
        @(negedge clk);
        checkOutput("wait3_tdr", start_counter3, 8'h5C);

        // Bus dropped mid-wait: no completion, TDR keeps its value
        @(posedge clk); #1;
        sel3 = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'h77;
        @(posedge clk); #1; penable = 1'b1;
        @(posedge clk); #1; psel = 1'b0; penable = 1'b0;
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (pready3 === 1'b1) saw = 1'b1;
        end
        checkOutput("abort_no_ready", 32'(saw), 32'd0);
        checkOutput("abort_tdr", start_counter3, 8'h5C);

        // Reset mid-wait: transfer discarded, registers back to reset values
        @(posedge clk); #1;
        sel3 = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'h99;
        @(posedge clk); #1; penable = 1'b1;
        saw = 1'b0;
        @(negedge clk); if (pready3 === 1'b1) saw = 1'b1;
        @(posedge clk); #1; rst3 = 1'b1;
        @(posedge clk); #1; rst3 = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (pready3 === 1'b1) saw = 1'b1;
        end
        checkOutput("rst_mid_no_ready", 32'(saw), 32'd0);
        checkOutput("rst_mid_tdr", start_counter3, 8'h00);
        @(posedge clk); #1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
